// File: rtl/countdown_sequencer.sv
// Drives a one-second countdown timer through ROUNDS back-to-back four-second
// countdowns, re-arming it between rounds and reporting progress to game/display logic.
module countdown_sequencer #(
    parameter int RW     = 2,
    parameter int ROUNDS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          countEnable,
    input  logic          countFinish,
    input  logic          flash,
    input  logic [1:0]    countDetail,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [3:0]    digit,
    output logic          blink,
    output logic [RW-1:0] round
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, DONE} state_t;

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t        state, state_nx;
    logic          finish_q;
    logic          fin_evt;
    logic [RW-1:0] round_nx;
    logic          enable_nx, busy_nx, done_nx, aborted_nx;

    // A finish flag that is already high when RUN is entered must not count.
    assign fin_evt = countFinish & ~finish_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx   = state;
        round_nx   = round;
        aborted_nx = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = ARM;
                    round_nx = '0;
                end
            end
            ARM:  state_nx = RUN;
            RUN: begin
                if (fin_evt) begin
                    if (round == LAST_ROUND) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = GAP;
                        round_nx = round + 1'b1;
                    end
                end
            end
            GAP:  state_nx = RUN;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Abort beats a simultaneous finish, so done never fires on an aborted sequence.
        if (abort && (state == ARM || state == RUN || state == GAP)) begin
            state_nx   = IDLE;
            round_nx   = '0;
            aborted_nx = 1'b1;
        end

        enable_nx = (state_nx == RUN);
        busy_nx   = (state_nx == ARM) || (state_nx == RUN) || (state_nx == GAP);
        done_nx   = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            finish_q    <= 1'b0;
            countEnable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            round       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state       <= state_nx;
            finish_q    <= countFinish;
            countEnable <= enable_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            aborted     <= aborted_nx;
            round       <= round_nx;
        end
    end

    // Display outputs follow the live timer while running and show a full count during re-arm.
    always_comb begin
        digit = 4'd0;
        blink = 1'b0;
        case (state)
            RUN: begin
                digit = 4'd4 - {2'b00, countDetail};
                blink = flash;
            end
            GAP:     digit = 4'd4;
            default: ;
        endcase
    end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Master/consumer side of the one-second countdown timer interface.
- Drives the timer's enable input and consumes its finish, flash and 2-bit detail outputs.
- Runs ROUNDS back-to-back four-second countdowns, re-arming the timer cleanly between rounds.
- Outputs a seconds-remaining digit, a blink LED, busy/done/aborted status to game control and display logic.

Parameters:
- ROUNDS, 3, number of timer countdowns per start; legal range 1..2^RW-1.
- RW, 2, width of the round counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled only in IDLE
- abort  input  1  level; cancels an active sequence
- countEnable  output  1  timer enable; registered
- countFinish  input  1  timer finish flag; high for one full timer tick
- flash  input  1  timer half-rate blink
- countDetail  input  2  timer tick index 0..3
- busy  output  1  high in ARM, RUN, GAP
- done  output  1  one-cycle pulse after the final round
- aborted  output  1  one-cycle pulse on abort
- digit  output  4  seconds remaining, 0..4
- blink  output  1  LED drive
- round  output  RW  index of the current round, 0-based

Behaviour:
- Reset (async, rst_n=0): state=IDLE; countEnable, busy, done, aborted, digit, blink, round all 0; finish_q=0.
- finish_q is countFinish registered every cycle. fin_evt = countFinish & ~finish_q (rising edge only).
- Each state drives countEnable and busy, registered and updated on the transition into the state.
- IDLE: countEnable=0, busy=0.
  - abort=1: stay in IDLE, no aborted pulse.
  - start=1 and abort=0: round<=0, go to ARM.
- ARM: one cycle with countEnable=0, so the timer clears its internal counter, flash and finish. Then go to RUN.
- RUN: countEnable=1.
  - digit = 4 - countDetail (4,3,2,1).
  - blink = flash.
  - On fin_evt with round==ROUNDS-1: go to DONE.
  - On fin_evt otherwise: round<=round+1, go to GAP.
- GAP: one cycle with countEnable=0 (timer re-arm). digit=4, blink=0. Then go to RUN.
- DONE: countEnable=0, done=1 for exactly one cycle, round holds its final value, then go to IDLE.
- Outside RUN and GAP: digit=0, blink=0.
- round stays valid in IDLE until the next start.
- Abort: in ARM, RUN or GAP, abort=1 means next state IDLE, countEnable<=0, aborted=1 for one cycle, round<=0.
  - abort has priority over fin_evt in the same cycle; done does not fire.
- start is ignored while busy, so a held start does not restart a running sequence.
- If start is still high on return to IDLE, a new sequence begins on the next cycle (level semantics).
- countFinish already high on entry to RUN is not an event; only a rising edge counts.
- Latency:
  - start to countEnable=1 is 2 clk (IDLE->ARM, ARM->RUN).
  - fin_evt on the final round to done is 1 clk.
  - Between rounds countEnable drops for exactly 1 clk.
- ROUNDS=1: the first fin_evt goes straight to DONE, with no GAP.
- countDetail and flash are used only in RUN; other values are don't-care.

Test Plan:
- The bench uses a behavioural timer model with a 10-clk tick that matches the timer's enable, clear, finish and detail semantics.
- Reset mid-RUN (rst_n low for 3 clk): all outputs 0 immediately, asynchronously. After release, state is IDLE and countEnable stays 0 until start.
- start pulse, ROUNDS=3: countEnable rises 2 clk later. digit steps 4,3,2,1 at each 10-clk tick. round goes 0->1->2. countEnable is low for exactly 1 clk after each of the first two finishes. done pulses once, 1 clk after the third countFinish rise. busy then falls.
- abort held for 1 clk during round 1 with digit=2: aborted pulses 1 clk. countEnable=0, round=0, digit=0 on the next cycle. No done.
- abort asserted in the same cycle as the final fin_evt: aborted=1, done=0, state IDLE.
- start held high continuously, ROUNDS=1: done pulses after 4 ticks. A new sequence starts 1 clk later (ARM). Toggling start mid-RUN has no effect.
- countFinish forced high when entering RUN: no round advance until the model drops it and raises it again.
